// File: rtl/pmp_pkg.sv
// Shared types and CSR numbers for the PMP CSR file and its cfg-byte legalizer.
package pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_a_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RESP
  } state_e;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

endpackage

// File: rtl/pmp_csr_file_if.sv
// Request/response CSR access bus between a requester (master) and the PMP CSR file (slave).
interface pmp_csr_file_if;
  import pmp_pkg::*;

  logic        csr_req_valid;
  logic        csr_req_ready;
  csr_op_e     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rsp_valid;
  logic        csr_rsp_ready;
  logic [31:0] csr_rsp_rdata;
  logic        csr_rsp_err;

  modport master (
    output csr_req_valid, csr_op, csr_addr, csr_wdata, csr_rsp_ready,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_err
  );

  modport slave (
    input  csr_req_valid, csr_op, csr_addr, csr_wdata, csr_rsp_ready,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, csr_rsp_err
  );
endinterface

// File: rtl/pmp_cfg_warl.sv
// Legalizes one proposed pmpNcfg byte against the stored byte and its lock bit.
// NA4 is only kept when PMP_NA4_EN is defined; otherwise it collapses to OFF.
module pmp_cfg_warl
  import pmp_pkg::*;
(
  input  pmpcfg_t old_i,
  input  pmpcfg_t prop_i,
  input  logic    lock_i,
  output pmpcfg_t legal_o
);

  always_comb begin
    legal_o      = prop_i;
    legal_o.rsvd = 2'b00;
`ifdef PMP_NA4_EN
    legal_o.a    = prop_i.a;
`else
    if (prop_i.a == A_NA4) begin
      legal_o.a = A_OFF;
    end
`endif
    // W without R is a reserved combination, so the whole byte is refused
    if (lock_i || (!prop_i.r && prop_i.w)) begin
      legal_o = old_i;
    end
  end

endmodule

// File: rtl/pmp_csr_file.sv
// PMP configuration/address CSR file with a three-state request/response engine.
// Optional feature macro: PMP_NA4_EN (keep A = NA4 in cfg bytes).
module pmp_csr_file
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  pmp_csr_file_if.slave                       csr,
  output logic [NUM_ENTRIES/4-1:0][31:0]      pmpcfg_data,
  output logic [NUM_ENTRIES-1:0][31:0]        pmpaddr_data,
  output logic                                cfg_update
);

  state_e                           state_q, state_d;
  csr_op_e                          reqOp_q;
  logic [11:0]                      reqAddr_q;
  logic [31:0]                      reqWdata_q;
  logic [31:0]                      rspRdata_q, rspRdata_d;
  logic                             rspErr_q, rspErr_d;
  pmpcfg_t [NUM_ENTRIES-1:0]        cfg_q, cfg_d;
  logic [NUM_ENTRIES-1:0][31:0]     pmpAddr_q, pmpAddr_d;
  logic                             update_q, update_d;

  logic        isCfg, isAddr, doWrite;
  logic [1:0]  cfgIdx;
  logic [3:0]  addrIdx;
  logic [31:0] oldVal, newVal;
  logic [NUM_ENTRIES-1:0] lockBit, torLock, addrLocked;
  pmpcfg_t     cfgProp  [NUM_ENTRIES];
  pmpcfg_t     cfgLegal [NUM_ENTRIES];

  assign isCfg   = (reqAddr_q[11:2] == CSR_PMPCFG0[11:2]);
  assign isAddr  = (reqAddr_q[11:4] == CSR_PMPADDR0[11:4]);
  assign cfgIdx  = reqAddr_q[1:0];
  assign addrIdx = reqAddr_q[3:0];
  assign doWrite = (state_q == S_CALC) && (reqOp_q != CSR_READ);

  always_comb begin
    oldVal = 32'h0;
    if (isCfg) begin
      oldVal = pmpcfg_data[cfgIdx];
    end else if (isAddr) begin
      oldVal = pmpAddr_q[addrIdx];
    end
    case (reqOp_q)
      CSR_WRITE: newVal = reqWdata_q;
      CSR_SET:   newVal = oldVal | reqWdata_q;
      CSR_CLEAR: newVal = oldVal & ~reqWdata_q;
      default:   newVal = oldVal;
    endcase
  end

  // Locks are evaluated on the stored (pre-operation) cfg, so a lock written now binds only later requests
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      lockBit[i] = cfg_q[i].l;
      torLock[i] = cfg_q[i].l && (cfg_q[i].a == A_TOR);
    end
    addrLocked = lockBit | (torLock >> 1);
  end

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_warl
    assign cfgProp[i] = (doWrite && isCfg && (cfgIdx == 2'(i / 4)))
                        ? pmpcfg_t'(newVal[8*(i%4) +: 8]) : cfg_q[i];
    pmp_cfg_warl u_warl (
      .old_i   (cfg_q[i]),
      .prop_i  (cfgProp[i]),
      .lock_i  (cfg_q[i].l),
      .legal_o (cfgLegal[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_d[i] = cfgLegal[i];
    end
    pmpAddr_d = pmpAddr_q;
    if (doWrite && isAddr && !addrLocked[addrIdx]) begin
      pmpAddr_d[addrIdx] = newVal;
    end
    update_d = (state_q == S_CALC) && ((cfg_d != cfg_q) || (pmpAddr_d != pmpAddr_q));
  end

  always_comb begin
    state_d    = state_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    case (state_q)
      S_IDLE: if (csr.csr_req_valid) state_d = S_CALC;
      S_CALC: begin
        state_d    = S_RESP;
        rspRdata_d = oldVal;
        rspErr_d   = !(isCfg || isAddr);
      end
      S_RESP: if (csr.csr_rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      reqOp_q    <= CSR_READ;
      reqAddr_q  <= 12'h0;
      reqWdata_q <= 32'h0;
      rspRdata_q <= 32'h0;
      rspErr_q   <= 1'b0;
      cfg_q      <= '0;
      pmpAddr_q  <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
      cfg_q      <= cfg_d;
      pmpAddr_q  <= pmpAddr_d;
      update_q   <= update_d;
      if (state_q == S_IDLE && csr.csr_req_valid) begin
        reqOp_q    <= csr.csr_op;
        reqAddr_q  <= csr.csr_addr;
        reqWdata_q <= csr.csr_wdata;
      end
    end
  end

  assign csr.csr_req_ready = (state_q == S_IDLE);
  assign csr.csr_rsp_valid = (state_q == S_RESP);
  assign csr.csr_rsp_rdata = rspRdata_q;
  assign csr.csr_rsp_err   = rspErr_q;
  assign pmpcfg_data       = cfg_q;
  assign pmpaddr_data      = pmpAddr_q;
  assign cfg_update        = update_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Directed scoreboard bench for pmp_csr_file; expected responses are queued at drive time.
module tb_pmp_csr_file;
  import pmp_pkg::*;

  logic clk;
  logic rst_n;
  logic [3:0][31:0]  pmpcfg_data;
  logic [15:0][31:0] pmpaddr_data;
  logic cfg_update;

  pmp_csr_file_if bus ();

  pmp_csr_file #(.NUM_ENTRIES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr          (bus.slave),
    .pmpcfg_data  (pmpcfg_data),
    .pmpaddr_data (pmpaddr_data),
    .cfg_update   (cfg_update)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          upd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int updCount = 0;

`ifdef PMP_NA4_EN
  localparam logic [31:0] NA4_EXP = 32'h0000_0010;
`else
  localparam logic [31:0] NA4_EXP = 32'h0000_0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cfg_update pulses away from the active edge
  always @(negedge clk) begin
    if (cfg_update) updCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input csr_op_e op, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr, input int expUpd, input int holdCycles);
    exp_t e;
    int n;
    int updBefore;
    e.tag = tag; e.rdata = expRdata; e.err = expErr; e.upd = expUpd;
    sb.push_back(e);
    updBefore = updCount;
    @(negedge clk);
    bus.csr_op        = op;
    bus.csr_addr      = addr;
    bus.csr_wdata     = wdata;
    bus.csr_req_valid = 1'b1;
    bus.csr_rsp_ready = (holdCycles == 0);
    n = 0;
    while (!bus.csr_req_ready && n < 50) begin @(negedge clk); n++; end
    checkOutput({tag, " accept"}, 32'(bus.csr_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.csr_req_valid = 1'b0;
    n = 0;
    while (!bus.csr_rsp_valid && n < 50) begin @(negedge clk); n++; end
    checkOutput({tag, " rsp_valid"}, 32'(bus.csr_rsp_valid), 32'd1);
    for (int k = 0; k < holdCycles; k++) begin
      checkOutput({tag, " hold valid"}, 32'(bus.csr_rsp_valid), 32'd1);
      checkOutput({tag, " hold ready"}, 32'(bus.csr_req_ready), 32'd0);
      @(negedge clk);
    end
    bus.csr_rsp_ready = 1'b1;
    e = sb.pop_front();
    checkOutput({e.tag, " rdata"}, bus.csr_rsp_rdata, e.rdata);
    checkOutput({e.tag, " err"}, 32'(bus.csr_rsp_err), 32'(e.err));
    @(posedge clk);
    @(negedge clk);
    checkOutput({e.tag, " cfg_update"}, 32'(updCount - updBefore), 32'(e.upd));
  endtask

  initial begin
    $display("[TB] start");
    rst_n             = 1'b0;
    bus.csr_req_valid = 1'b0;
    bus.csr_op        = CSR_READ;
    bus.csr_addr      = 12'h0;
    bus.csr_wdata     = 32'h0;
    bus.csr_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset req_ready", 32'(bus.csr_req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
    checkOutput("reset rdata", bus.csr_rsp_rdata, 32'h0);
    checkOutput("reset err", 32'(bus.csr_rsp_err), 32'd0);
    checkOutput("reset cfg_update", 32'(cfg_update), 32'd0);
    checkOutput("reset pmpcfg0", pmpcfg_data[0], 32'h0);

    applyStimulus("w cfg0 RW01", CSR_WRITE, 12'h3A0, 32'h0000_0002, 32'h0, 1'b0, 0, 0);
    checkOutput("cfg0 after RW01", pmpcfg_data[0], 32'h0);
    applyStimulus("w cfg0 0F0B", CSR_WRITE, 12'h3A0, 32'h0000_0F0B, 32'h0, 1'b0, 1, 0);
    applyStimulus("r cfg0", CSR_READ, 12'h3A0, 32'h0, 32'h0000_0F0B, 1'b0, 0, 0);
    applyStimulus("set cfg0 zero", CSR_SET, 12'h3A0, 32'h0, 32'h0000_0F0B, 1'b0, 0, 0);
    applyStimulus("clr cfg0 byte1", CSR_CLEAR, 12'h3A0, 32'h0000_0F00, 32'h0000_0F0B, 1'b0, 1, 0);
    checkOutput("cfg0 after clr", pmpcfg_data[0], 32'h0000_000B);
    applyStimulus("w cfg0 NA4", CSR_WRITE, 12'h3A0, 32'h0000_0010, 32'h0000_000B, 1'b0, 1, 0);
    checkOutput("cfg0 NA4", pmpcfg_data[0], NA4_EXP);
    applyStimulus("w cfg0 rsvd", CSR_WRITE, 12'h3A0, 32'h0000_0061, NA4_EXP, 1'b0, 1, 0);
    checkOutput("cfg0 rsvd cleared", pmpcfg_data[0], 32'h0000_0001);

    applyStimulus("w addr2", CSR_WRITE, 12'h3B2, 32'h0000_1234, 32'h0, 1'b0, 1, 0);
    applyStimulus("r addr2", CSR_READ, 12'h3B2, 32'h0, 32'h0000_1234, 1'b0, 0, 0);
    checkOutput("pmpaddr2 out", pmpaddr_data[2], 32'h0000_1234);

    applyStimulus("w cfg0 lock1", CSR_WRITE, 12'h3A0, 32'h0000_8900, 32'h0000_0001, 1'b0, 1, 0);
    checkOutput("cfg0 locked", pmpcfg_data[0], 32'h0000_8900);
    applyStimulus("w addr0 tor", CSR_WRITE, 12'h3B0, 32'h0000_1234, 32'h0, 1'b0, 0, 0);
    applyStimulus("w addr1 lock", CSR_WRITE, 12'h3B1, 32'h0000_5678, 32'h0, 1'b0, 0, 0);
    applyStimulus("r addr0", CSR_READ, 12'h3B0, 32'h0, 32'h0, 1'b0, 0, 0);
    applyStimulus("r addr1", CSR_READ, 12'h3B1, 32'h0, 32'h0, 1'b0, 0, 0);
    applyStimulus("w cfg0 byte0", CSR_WRITE, 12'h3A0, 32'h0000_0003, 32'h0000_8900, 1'b0, 1, 0);
    checkOutput("cfg0 lock kept", pmpcfg_data[0], 32'h0000_8903);
    applyStimulus("clr cfg0 all", CSR_CLEAR, 12'h3A0, 32'hFFFF_FFFF, 32'h0000_8903, 1'b0, 1, 0);
    checkOutput("cfg0 clr locked", pmpcfg_data[0], 32'h0000_8900);

    applyStimulus("r illegal hold", CSR_READ, 12'h3C0, 32'h0, 32'h0, 1'b1, 0, 5);
    applyStimulus("w illegal", CSR_WRITE, 12'h3A4, 32'h0000_FFFF, 32'h0, 1'b1, 0, 0);
    checkOutput("cfg0 after illegal", pmpcfg_data[0], 32'h0000_8900);

    applyStimulus("w addr15", CSR_WRITE, 12'h3BF, 32'h0000_ABCD, 32'h0, 1'b0, 1, 0);
    applyStimulus("set addr15", CSR_SET, 12'h3BF, 32'h0000_0030, 32'h0000_ABCD, 1'b0, 1, 0);
    checkOutput("pmpaddr15 out", pmpaddr_data[15], 32'h0000_ABFD);

    // Reset lands while the pmpaddr3 write sits in CALC
    @(negedge clk);
    bus.csr_op        = CSR_WRITE;
    bus.csr_addr      = 12'h3B3;
    bus.csr_wdata     = 32'h0000_FFFF;
    bus.csr_req_valid = 1'b1;
    bus.csr_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("inflight busy", 32'(bus.csr_req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
    checkOutput("rst pmpaddr3", pmpaddr_data[3], 32'h0);
    checkOutput("rst pmpcfg0", pmpcfg_data[0], 32'h0);
    @(negedge clk);
    bus.csr_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-rst req_ready", 32'(bus.csr_req_ready), 32'd1);
    checkOutput("post-rst rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
    checkOutput("post-rst pmpaddr3", pmpaddr_data[3], 32'h0);
    checkOutput("post-rst pmpaddr15", pmpaddr_data[15], 32'h0);

    applyStimulus("w addr1 unlocked", CSR_WRITE, 12'h3B1, 32'h0000_5678, 32'h0, 1'b0, 1, 0);
    checkOutput("pmpaddr1 out", pmpaddr_data[1], 32'h0000_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmp_csr_file.md
PMP_CSR_FILE -- requirements
Module: pmp_csr_file

Interface
REQ-001 SHALL have parameter: NUM_ENTRIES, 16, number of PMP entries (only 16 supported).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: csr_req_valid in 1 request present; csr_req_ready out 1 request accepted when both high.
REQ-005 SHALL have ports: csr_op in 2 (00 read, 01 write, 10 set, 11 clear); csr_addr in 12 CSR number; csr_wdata in 32 operand.
REQ-006 SHALL have ports: csr_rsp_valid out 1; csr_rsp_ready in 1; csr_rsp_rdata out 32 pre-operation value; csr_rsp_err out 1 illegal CSR number.
REQ-007 SHALL have ports: pmpcfg_data out 4x32 pmpcfg0..3; pmpaddr_data out 16x32 pmpaddr0..15, to the PMP checker.
REQ-008 SHALL have ports: cfg_update out 1, one-cycle pulse when any stored bit changes.

Function
REQ-009 SHALL decode 0x3A0-0x3A3 as pmpcfg0-3 and 0x3B0-0x3BF as pmpaddr0-15; any other csr_addr is illegal.
REQ-010 SHALL run FSM IDLE -> CALC -> RESP -> IDLE; csr_req_ready = 1 only in IDLE.
REQ-011 SHALL latch op/addr/wdata on acceptance in cycle N; CALC in N+1 computes and commits the new value on the N+1 closing edge; RESP from N+2.
REQ-012 SHALL hold csr_rsp_valid, rdata, err stable in RESP until csr_rsp_ready; return to IDLE on that edge (no back-to-back acceptance in same cycle).
REQ-013 SHALL compute new value: write = wdata; set = old | wdata; clear = old & ~wdata; read performs no write.
REQ-014 SHALL return rdata = value before the operation; illegal address: rdata = 0, err = 1, no state change.
REQ-015 SHALL legalize each cfg byte independently: bits [6:5] stored as 0; a byte with R=0,W=1 keeps its old value entirely.
REQ-016 SHALL ignore writes to cfg byte i and pmpaddr i when pmpi.L = 1; L clears only on reset.
REQ-017 SHALL ignore writes to pmpaddr i when pmp(i+1).L = 1 and pmp(i+1).A = TOR (i < 15).
REQ-018 SHALL apply lock checks against pre-operation state; a write setting L takes effect for later requests only.
REQ-019 SHALL pulse cfg_update in the cycle after commit only if the stored value differed; set/clear with wdata = 0 gives no pulse.
REQ-020 SHALL drive pmpcfg_data/pmpaddr_data directly from storage (no added latency after commit).

Reset
REQ-021 SHALL on rst_n low asynchronously clear all pmpcfg/pmpaddr storage, enter IDLE, drive csr_req_ready = 1 after release, csr_rsp_valid = 0, rdata = 0, err = 0, cfg_update = 0.
REQ-022 SHALL abandon any in-flight request on reset, including one in CALC; no partial commit.

Configuration
REQ-023 SHALL, with PMP_NA4_EN defined, store A = NA4 (2'b10) as written.
REQ-024 SHALL, without PMP_NA4_EN, store A = OFF when NA4 is written; other A encodings unchanged.

Structure
REQ-025 SHALL place in pmp_pkg: pmpcfg packed struct (L, rsvd[1:0], A[1:0], X, W, R), A-field enum (OFF, TOR, NA4, NAPOT), csr_op enum, CSR base-number constants.
REQ-026 SHALL use one sub-module pmp_cfg_warl, instantiated per cfg byte: old byte, proposed byte, lock -> legal byte.

Verification
REQ-027 SHALL cover: write 0x3A0 = 0x0000_0F0B, then read -> rsp rdata 0x0000_0F0B... with byte1 0x0F kept? no: byte0 0x0B legal, byte1 0x0F legal; read returns 0x0000_0F0B, err = 0.
REQ-028 SHALL cover: write 0x3A0 = 0x0000_0002 (R=0,W=1) from reset -> stored 0x0000_0000, cfg_update not pulsed.
REQ-029 SHALL cover: write pmp1cfg = 0x89 (L, TOR, R), then write pmpaddr0 = 0x1234 and pmpaddr1 = 0x5678 -> both read 0x0.
REQ-030 SHALL cover: write 0x3A0 = 0x10 -> stored 0x10 with PMP_NA4_EN, 0x00 without.
REQ-031 SHALL cover: read 0x3C0 -> err = 1, rdata = 0, no cfg_update; csr_rsp_ready held low 5 cycles -> rsp_valid held, ready stays 0.
REQ-032 SHALL cover: rst_n asserted during CALC of write pmpaddr3 = 0xFFFF -> pmpaddr3 = 0, rsp_valid = 0, IDLE after release.
